// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions for the tx-only master and rx-only slave.
// Provides the byte width and SPI mode decode (CPOL/CPHA from mode 0..3).
// Purely combinational helpers; no state.
package spi_pkg;

  localparam int BYTE_W = 8;

  // Clock idles high in modes 2 and 3.
  function automatic logic cpol_of(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  // Data is sampled on the trailing edge in modes 1 and 3.
  function automatic logic cpha_of(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a parameterized reset value.
// Latency: 2 clk_i cycles from d to q. No backpressure (free-running).
// Ports: clk_i, rst_i (async active-low), d (asynchronous input), q (synchronized).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/spi_slave_only_rx.sv
// spi_slave_only_rx: receive-only SPI slave (spi_clk + spi_mosi, no chip select),
// oversampled in the clk_i domain. Latency: valid strobe 3 clk_i cycles after the
// 8th sampling edge is first captured. No backpressure: each byte overwrites data_o.
// Ports: clk_i, rst_i (async active-low), spi_clk_i, spi_mosi_i (async inputs),
//   data_o (last byte, MSb first), data_out_valid_strobe_o, rx_busy_o, timeout_strobe_o.
// Optional: define SPI_RX_TIMEOUT_EN to discard partial bytes after
//   IDLE_TIMEOUT_CYCLES clk_i cycles without a sampling edge.
module spi_slave_only_rx
  import spi_pkg::*;
#(
  parameter int SPI_MODE            = 0,
  parameter int IDLE_TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic [BYTE_W-1:0] data_o,
  output logic              data_out_valid_strobe_o,
  output logic              rx_busy_o,
  output logic              timeout_strobe_o
);

  localparam logic CPOL = cpol_of(SPI_MODE);
  localparam logic CPHA = cpha_of(SPI_MODE);

  logic sclk_s2, sclk_s3, mosi_s2;
  logic lead_edge, trail_edge, samp;

  // The shift register only holds the first 7 bits; the 8th goes straight to data_o.
  logic [BYTE_W-2:0] shift_reg, shift_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic              byte_done, byte_done_q;
  logic              tmo_expire;

  // Clock synchronizer resets to the idle level so reset release shows no edge.
  sync_2ff #(.RST_VAL(CPOL)) u_sync_clk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (spi_clk_i),
    .q     (sclk_s2)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (spi_mosi_i),
    .q     (mosi_s2)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sclk_s3 <= CPOL;
    else        sclk_s3 <= sclk_s2;
  end

  // Leading edge leaves the idle level; trailing edge returns to it.
  assign lead_edge  = (sclk_s2 != sclk_s3) && (sclk_s3 == CPOL);
  assign trail_edge = (sclk_s2 != sclk_s3) && (sclk_s3 != CPOL);
  assign samp       = CPHA ? trail_edge : lead_edge;

  always_comb begin
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    byte_done   = 1'b0;
    if (samp) begin
      shift_nxt   = {shift_reg[BYTE_W-3:0], mosi_s2};
      bit_cnt_nxt = bit_cnt + 3'd1;
      byte_done   = (bit_cnt == 3'd7);
    end else if (tmo_expire) begin
      shift_nxt   = '0;
      bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_reg               <= '0;
      bit_cnt                 <= '0;
      data_o                  <= '0;
      byte_done_q             <= 1'b0;
      data_out_valid_strobe_o <= 1'b0;
      rx_busy_o               <= 1'b0;
      timeout_strobe_o        <= 1'b0;
    end else begin
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      byte_done_q <= byte_done;
      if (byte_done) data_o <= {shift_reg, mosi_s2};
      // Strobe follows the data_o update by one cycle.
      data_out_valid_strobe_o <= byte_done_q;
      rx_busy_o               <= (bit_cnt_nxt != 3'd0);
      timeout_strobe_o        <= tmo_expire;
    end
  end

`ifdef SPI_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Expire on the cycle the counter would step to IDLE_TIMEOUT_CYCLES; a
  // sampling edge in that same cycle takes priority and clears the counter.
  assign tmo_expire = !samp && (bit_cnt != 3'd0) &&
                      (idle_cnt == IDLE_W'(IDLE_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                   idle_cnt <= '0;
    else if (samp || bit_cnt == 3'd0 || tmo_expire) idle_cnt <= '0;
    else                                          idle_cnt <= idle_cnt + IDLE_W'(1);
  end
`else
  // Without the timeout, framing only recovers through rst_i.
  assign tmo_expire = 1'b0;
  logic unused_idle_cfg;
  assign unused_idle_cfg = |IDLE_TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_spi_slave_only_rx.sv
module tb_spi_slave_only_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sclk0, mosi0, sclk3, mosi3;
  logic [7:0] data0, data3;
  logic       vld0, busy0, tmo0;
  logic       vld3, busy3, tmo3;

  int checks = 0;
  int errors = 0;
  int vcnt0  = 0;
  int vcnt3  = 0;
  int tcnt0  = 0;
  logic [7:0] log0[$];

  spi_slave_only_rx #(.SPI_MODE(0), .IDLE_TIMEOUT_CYCLES(64)) dut0 (
    .clk_i                   (clk),
    .rst_i                   (rst_n),
    .spi_clk_i               (sclk0),
    .spi_mosi_i              (mosi0),
    .data_o                  (data0),
    .data_out_valid_strobe_o (vld0),
    .rx_busy_o               (busy0),
    .timeout_strobe_o        (tmo0)
  );

  spi_slave_only_rx #(.SPI_MODE(3), .IDLE_TIMEOUT_CYCLES(64)) dut3 (
    .clk_i                   (clk),
    .rst_i                   (rst_n),
    .spi_clk_i               (sclk3),
    .spi_mosi_i              (mosi3),
    .data_o                  (data3),
    .data_out_valid_strobe_o (vld3),
    .rx_busy_o               (busy3),
    .timeout_strobe_o        (tmo3)
  );

  // Count strobe-high cycles: a count of exactly one per byte also proves one-cycle pulses.
  always @(negedge clk) begin
    if (vld0) begin
      vcnt0++;
      log0.push_back(data0);
    end
    if (vld3) vcnt3++;
    if (tmo0) tcnt0++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 master, CLKS_PER_HALF_BIT=2: data set during low phase, rising edge samples.
  task automatic send0(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi0 = b[i];
      cyc(2);
      sclk0 = 1'b1;
      cyc(2);
      sclk0 = 1'b0;
    end
  endtask

  // Mode 3 master: clock idles high, data changes on the falling edge, rising edge samples.
  task automatic send3(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sclk3 = 1'b0;
      mosi3 = b[i];
      cyc(2);
      sclk3 = 1'b1;
      cyc(2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sclk0 = 1'b0;
    mosi0 = 1'b0;
    sclk3 = 1'b1;
    mosi3 = 1'b0;
    cyc(3);

    // Reset state
    check("rst_data0", data0, 8'h00);
    check("rst_vld0", vld0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_tmo0", tmo0, 1'b0);
    check("rst_data3", data3, 8'h00);
    check("rst_busy3", busy3, 1'b0);

    // Release with mode-3 clock already high: no spurious edge
    rst_n = 1'b1;
    cyc(5);
    check("m3_noedge_busy", busy3, 1'b0);
    check("m3_noedge_vld", vcnt3, 0);

    // Mode 0 single byte 0xA5
    send0(8'hA5, 7, 4);
    cyc(2);
    check("a5_busy_mid", busy0, 1'b1);
    send0(8'hA5, 3, 0);
    cyc(6);
    check("a5_count", vcnt0, 1);
    check("a5_data", data0, 8'hA5);
    check("a5_busy_after", busy0, 1'b0);

    // Back-to-back 0x3C, 0xC3
    send0(8'h3C, 7, 0);
    send0(8'hC3, 7, 0);
    cyc(6);
    check("b2b_count", vcnt0, 3);
    check("b2b_first", log0[1], 8'h3C);
    check("b2b_second", log0[2], 8'hC3);

    // Mode 3 byte 0x81
    send3(8'h81);
    cyc(6);
    check("m3_count", vcnt3, 1);
    check("m3_data", data3, 8'h81);
    check("m3_busy_after", busy3, 1'b0);

    // Reset mid-byte, then 0x0F
    send0(8'hF0, 7, 4);
    cyc(2);
    check("rstmid_busy", busy0, 1'b1);
    rst_n = 1'b0;
    cyc(2);
    check("rstmid_data", data0, 8'h00);
    check("rstmid_busy_rst", busy0, 1'b0);
    rst_n = 1'b1;
    cyc(3);
    send0(8'h0F, 7, 0);
    cyc(6);
    check("rstmid_count", vcnt0, 4);
    check("rstmid_newdata", data0, 8'h0F);

`ifdef SPI_RX_TIMEOUT_EN
    // 5 bits then stall past the timeout
    send0(8'hFF, 7, 3);
    cyc(80);
    check("tmo_strobe_count", tcnt0, 1);
    check("tmo_no_valid", vcnt0, 4);
    check("tmo_busy", busy0, 1'b0);
    check("tmo_data_held", data0, 8'h0F);
    send0(8'h5A, 7, 0);
    cyc(6);
    check("tmo_recover_count", vcnt0, 5);
    check("tmo_recover_data", data0, 8'h5A);

    // 4th sampling edge exactly 64 cycles after the 3rd: edge wins over expiry
    send0(8'hC6, 7, 5);
    mosi0 = 1'b0;
    cyc(62);
    sclk0 = 1'b1;
    cyc(2);
    sclk0 = 1'b0;
    send0(8'hC6, 3, 0);
    cyc(6);
    check("tmo_edge_no_strobe", tcnt0, 1);
    check("tmo_edge_count", vcnt0, 6);
    check("tmo_edge_data", data0, 8'hC6);
`else
    check("no_tmo_strobe", tcnt0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_only_rx.md
Name: spi_slave_only_rx

Overview:
SPI receive-only slave. It recovers bytes sent by the team's SPI tx-only master over a 2-wire link (spi_clk, spi_mosi), with no chip select.
- Runs entirely in the local clk_i domain: SPI pins are oversampled through synchronizers, and bit sampling is done on detected SPI clock edges.
- Delivers each completed byte, MSb first, as a parallel word with a one-cycle valid strobe.
- Sits at the receiving end of the wave-generator control/data link.

Parameters:
- SPI_MODE, 0, SPI mode 0..3. CPOL = (mode 2 or 3); CPHA = (mode 1 or 3).
- IDLE_TIMEOUT_CYCLES, 64, clk_i cycles without a sampling edge before a partial byte is discarded. Used only when SPI_RX_TIMEOUT_EN is defined. Must be ≥ 4×CLKS_PER_HALF_BIT of the master.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- spi_clk_i  in  1  SPI clock from master; asynchronous to clk_i.
- spi_mosi_i  in  1  SPI data from master; asynchronous to clk_i.
- data_o  out  8  last completed byte; held until the next byte completes.
- data_out_valid_strobe_o  out  1  one-cycle pulse when data_o is updated.
- rx_busy_o  out  1  high while a byte is partially received (1..7 bits captured).
- timeout_strobe_o  out  1  one-cycle pulse when a partial byte is discarded. Constant 0 without SPI_RX_TIMEOUT_EN.

Behaviour:
- Reset (rst_i low, asynchronous):
  - data_o = 0; both strobes = 0; rx_busy_o = 0; bit counter = 0; shift register = 0.
  - All synchronizer stages for spi_clk load CPOL, so no false edge is seen on release.
  - Synchronizer stages for spi_mosi load 0.
  - Reset mid-byte discards the partial byte with no strobe.
- Synchronization:
  - spi_clk_i and spi_mosi_i each pass through 2 flops (s1, s2). spi_clk also has a third flop, s3, as the edge reference.
  - Leading edge = s2 != s3 with s3 == CPOL. Trailing edge = s2 != s3 with s3 != CPOL.
- Sampling edge:
  - CPHA=0: leading edge. CPHA=1: trailing edge.
  - The other edge type is ignored.
  - On a sampling edge, shift_reg = {shift_reg[6:0], mosi_s2} and the bit counter increments (3-bit, wraps 7→0).
- Byte completion:
  - On the sampling edge with bit counter == 7, data_o is loaded with {shift_reg[6:0], mosi_s2} and the strobe pulses in the next cycle (registered).
  - Latency: the strobe is high 3 clk_i cycles after the first clk_i edge that captures the 8th sampling SPI edge on the pin.
- Back-to-back bytes: bit 0 of the next byte may be sampled in the same cycle the strobe is high. No gap is required and no data is lost.
- No flow control: a new byte overwrites data_o unconditionally. The consumer must take data_o on the strobe.
- rx_busy_o = (bit counter != 0), registered.
- Input-rate limit: SPI half-period must be ≥ 2 clk_i cycles. Faster input is unsupported; behaviour is undefined.
- Simultaneous sampling edge and timeout expiry: the edge wins, the timeout counter clears, and no timeout_strobe_o is issued.

Optional Feature:
- Macro SPI_RX_TIMEOUT_EN.
- Defined:
  - An idle counter of width clog2(IDLE_TIMEOUT_CYCLES+1) clears on every sampling edge and increments while rx_busy_o is high.
  - When it reaches IDLE_TIMEOUT_CYCLES, the bit counter and shift register clear and timeout_strobe_o pulses for one cycle.
  - data_o is unchanged and no valid strobe is issued.
  - The counter holds at 0 while idle (bit counter == 0).
- Undefined: there is no idle counter, timeout_strobe_o is tied to 0, and framing recovers only via rst_i.

Decomposition:
- Shared package spi_pkg:
  - SPI mode decode constants/functions (CPOL, CPHA from mode), also adopted by the tx master.
  - BYTE_W = 8.
- One sub-module: sync_2ff, a parameterized-reset-value 2-flop synchronizer, instantiated for spi_clk and spi_mosi.

Test Plan:
1. Mode 0, master CLKS_PER_HALF_BIT=2, send 0xA5 → exactly one data_out_valid_strobe_o with data_o=0xA5; rx_busy_o high during the transfer, low after.
2. Mode 0, back-to-back 0x3C then 0xC3 with no idle between bytes → two strobes, data_o=0x3C then 0xC3, no missed or duplicated bit.
3. SPI_MODE=3 (CPOL=1, CPHA=1), send 0x81 with the clock idling high; release reset with spi_clk_i=1 → data_o=0x81, and no spurious edge after reset.
4. SPI_RX_TIMEOUT_EN, IDLE_TIMEOUT_CYCLES=64:
   - Send 5 bits of 0xFF, then stall 64 cycles → timeout_strobe_o pulses once, no valid strobe, rx_busy_o=0.
   - Then send 0x5A → data_o=0x5A.
5. Assert rst_i low after 4 bits of 0xF0, release, then send 0x0F → data_o resets to 0x00, then a single strobe with data_o=0x0F.
6. Timeout edge case: a sampling edge lands on the cycle the idle counter would expire (counter=63→64 with an edge) → no timeout_strobe_o, and the byte completes normally.
